// File: rtl/wb_bus_master.sv
// Single-outstanding pipelined Wishbone initiator.
// Converts one client valid/ready request into one bus cycle and returns
// exactly one response strobe. Handles stall, rty with bounded reissue,
// err, and a watchdog so a silent slave cannot hang the client.
//
// Client handshake: a request transfers at a clk_bus edge where req_valid
// and req_ready are both 1. req_ready is high only in IDLE, and the response
// cycle is already IDLE, so a new request may be presented in that cycle.
// resp_valid is a single-cycle strobe with no back-pressure.
module wb_bus_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DATA_W / 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk_bus,
  input  logic              rst_bus,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_dat,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              cyc_o,
  output logic              stb_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  input  logic              err_i,
  input  logic              rty_i,
  input  logic              stall_i,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_BACKOFF = 2'd3;

  localparam int RCNT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RCNT_W-1:0] RETRY_MAX = RCNT_W'(MAX_RETRY);
  localparam logic [7:0]        TIMER_MAX = 8'(TIMEOUT);

  logic [1:0]        state;
  logic [RCNT_W-1:0] retry_cnt;
  logic [7:0]        timer;

  // Outcome decode for the current cycle; the bus fields act as the
  // latched request, so a reissue after BACKOFF reuses them unchanged.
  logic              fin;
  logic              fin_err;
  logic              fin_to;
  logic [DATA_W-1:0] fin_dat;
  logic              go_backoff;

  assign dbg_state = state;

  // Decide whether this edge completes the request, and with what result.
  always_comb begin
    fin        = 1'b0;
    fin_err    = 1'b0;
    fin_to     = 1'b0;
    fin_dat    = '0;
    go_backoff = 1'b0;
    case (state)
      S_ISSUE: begin
        // Bus outcomes are not sampled while the strobe is outstanding.
        if (timer == TIMER_MAX) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_to  = 1'b1;
        end
      end
      S_WAIT: begin
        // ack beats err beats rty; any bus outcome beats the watchdog.
        if (ack_i) begin
          fin     = 1'b1;
          fin_dat = we_o ? '0 : dat_i;
        end else if (err_i) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (rty_i) begin
          if (retry_cnt < RETRY_MAX) begin
            go_backoff = 1'b1;
          end else begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end
        end else if (timer == TIMER_MAX) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_to  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Request FSM, bus outputs, retry counter, watchdog and response registers.
  always_ff @(posedge clk_bus) begin
    if (!rst_bus) begin
      state        <= S_IDLE;
      req_ready    <= 1'b0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      we_o         <= 1'b0;
      adr_o        <= '0;
      dat_o        <= '0;
      sel_o        <= '0;
      resp_valid   <= 1'b0;
      resp_dat     <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (fin) begin
        state        <= S_IDLE;
        req_ready    <= 1'b1;
        cyc_o        <= 1'b0;
        stb_o        <= 1'b0;
        resp_valid   <= 1'b1;
        resp_dat     <= fin_dat;
        resp_err     <= fin_err;
        resp_timeout <= fin_to;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              we_o      <= req_we;
              adr_o     <= req_adr;
              dat_o     <= req_dat;
              sel_o     <= req_sel;
              cyc_o     <= 1'b1;
              stb_o     <= 1'b1;
              retry_cnt <= '0;
              timer     <= '0;
              req_ready <= 1'b0;
              state     <= S_ISSUE;
            end else begin
              req_ready <= 1'b1;
            end
          end
          S_ISSUE: begin
            timer <= timer + 8'd1;
            if (!stall_i) begin
              stb_o <= 1'b0;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (go_backoff) begin
              retry_cnt <= retry_cnt + 1'b1;
              cyc_o     <= 1'b0;
              state     <= S_BACKOFF;
            end else begin
              timer <= timer + 8'd1;
            end
          end
          S_BACKOFF: begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            timer <= '0;
            state <= S_ISSUE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_master.sv
// Testbench for wb_bus_master: scripted Wishbone slave, response scoreboard
// and one task per scenario.
module tb_wb_bus_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  localparam int OUT_ACK    = 0;
  localparam int OUT_ERR    = 1;
  localparam int OUT_RTY    = 2;
  localparam int OUT_ACKERR = 3;

  logic          clk_bus = 1'b0;
  logic          rst_bus;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [SW-1:0] req_sel;
  logic          resp_valid;
  logic [DW-1:0] resp_dat;
  logic          resp_err;
  logic          resp_timeout;
  logic          cyc_o;
  logic          stb_o;
  logic          we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [SW-1:0] sel_o;
  logic [DW-1:0] dat_i;
  logic          ack_i;
  logic          err_i;
  logic          rty_i;
  logic          stall_i;
  logic [1:0]    dbg_state;

  wb_bus_master dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_dat(resp_dat), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i), .ack_i(ack_i),
    .err_i(err_i), .rty_i(rty_i), .stall_i(stall_i), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 clk_bus = ~clk_bus;

  int cyc_cnt = 0;
  always @(posedge clk_bus) cyc_cnt <= cyc_cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [DW+1:0] exp_q[$];   // {resp_err, resp_timeout, resp_dat}
  logic [DW+1:0] mon_exp;

  // ---------------- scripted slave ----------------
  int            out_q[$];
  int            stall_cfg = 0;
  int            stall_left = 0;
  bit            pend = 1'b0;
  bit            stray_req = 1'b0;
  logic [DW-1:0] rd_data = '0;

  // Outcome arrives in the cycle after the strobe is accepted; an empty
  // script means the slave stays silent.
  initial begin
    int o;
    ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; stall_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk_bus);
      ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
      dat_i = rd_data;
      if (stray_req) begin
        ack_i = 1'b1;
        stray_req = 1'b0;
      end
      if (pend) begin
        pend = 1'b0;
        if (out_q.size() > 0) begin
          o = out_q.pop_front();
          case (o)
            OUT_ACK:    ack_i = 1'b1;
            OUT_ERR:    err_i = 1'b1;
            OUT_RTY:    rty_i = 1'b1;
            OUT_ACKERR: begin ack_i = 1'b1; err_i = 1'b1; end
            default: ;
          endcase
        end
      end
      if (cyc_o === 1'b1 && stb_o === 1'b1) begin
        if (stall_left > 0) begin
          stall_i = 1'b1;
          stall_left--;
        end else begin
          stall_i = 1'b0;
          pend = 1'b1;
          stall_left = stall_cfg;
        end
      end else begin
        stall_i = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk_bus);
      if (resp_valid === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp: got resp err=%b to=%b dat=%h, required no response",
                   resp_err, resp_timeout, resp_dat);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({resp_err, resp_timeout, resp_dat} !== mon_exp) begin
            miscompares++;
            $display("FAIL resp_fields: got err=%b to=%b dat=%h, required err=%b to=%b dat=%h",
                     resp_err, resp_timeout, resp_dat, mon_exp[DW+1], mon_exp[DW], mon_exp[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver / observation tasks ----------------
  int            hs_cycle;
  logic          cur_we;
  logic [AW-1:0] cur_adr;
  logic [DW-1:0] cur_dat;
  logic [SW-1:0] cur_sel;

  int obs_strobes, obs_stb_cycles, obs_gaps, obs_resp, obs_resp_cycle;
  int obs_first_stb, obs_bad_fields;
  logic obs_cyc_at_resp;

  task automatic set_slave(input int stall);
    stall_cfg  = stall;
    stall_left = stall;
  endtask

  // Called at a negedge; presents one request and returns at the next negedge.
  task automatic do_req(input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] dat, input logic [SW-1:0] sel,
                        input logic [DW+1:0] exp, input bit push);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1) begin
      @(negedge clk_bus);
      guard++;
      if (guard > 50) begin
        vectors++;
        miscompares++;
        $display("FAIL req_ready_bound: got req_ready=%b for 50 cycles, required 1", req_ready);
        return;
      end
    end
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    req_valid = 1'b1;
    hs_cycle = cyc_cnt;
    cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
    if (push) exp_q.push_back(exp);
    @(negedge clk_bus);
    req_valid = 1'b0;
    req_we  = 1'($urandom_range(0, 1));
    req_adr = $urandom;
    req_dat = $urandom;
    req_sel = 4'($urandom_range(0, 15));
  endtask

  // Samples bus activity each negedge until a response plus `settle` cycles.
  task automatic observe(input int max_cycles, input int settle);
    int   n;
    int   left;
    bit   seen;
    logic prev_stb;
    n = 0; left = settle; seen = 1'b0; prev_stb = 1'b0;
    obs_strobes = 0; obs_stb_cycles = 0; obs_gaps = 0; obs_resp = 0;
    obs_resp_cycle = -1; obs_first_stb = -1; obs_bad_fields = 0;
    obs_cyc_at_resp = 1'bx;
    forever begin
      if (stb_o === 1'b1) begin
        obs_stb_cycles++;
        if (prev_stb !== 1'b1) obs_strobes++;
        if (obs_first_stb < 0) obs_first_stb = cyc_cnt;
        if ({we_o, adr_o, dat_o, sel_o} !== {cur_we, cur_adr, cur_dat, cur_sel})
          obs_bad_fields++;
      end
      if (!seen && obs_first_stb >= 0 && cyc_o === 1'b0 && resp_valid !== 1'b1)
        obs_gaps++;
      prev_stb = stb_o;
      if (resp_valid === 1'b1) begin
        obs_resp++;
        if (!seen) begin
          obs_resp_cycle = cyc_cnt;
          obs_cyc_at_resp = cyc_o;
        end
        seen = 1'b1;
      end
      if (seen) begin
        if (left == 0) break;
        left--;
      end
      n++;
      if (n >= max_cycles) begin
        if (!seen) begin
          vectors++;
          miscompares++;
          $display("FAIL resp_bound: got no resp_valid in %0d cycles, required one", max_cycles);
        end
        break;
      end
      @(negedge clk_bus);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_bus = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    @(negedge clk_bus);
    @(negedge clk_bus);
    vectors++;
    if ({cyc_o, stb_o, we_o, resp_valid, resp_err, resp_timeout} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got cyc/stb/we/rv/re/rt=%b, required 000000",
               {cyc_o, stb_o, we_o, resp_valid, resp_err, resp_timeout});
    end
    vectors++;
    if ({adr_o, dat_o, sel_o, resp_dat} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got adr=%h dat=%h sel=%h rdat=%h, required all 0",
               adr_o, dat_o, sel_o, resp_dat);
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, required 0", req_ready);
    end
    rst_bus = 1'b1;
    @(negedge clk_bus);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_read();
    set_slave(0);
    rd_data = 32'hDEADBEEF;
    out_q.push_back(OUT_ACK);
    do_req(1'b0, 32'h0000_0040, $urandom, 4'hF, {2'b00, 32'hDEADBEEF}, 1'b1);
    observe(20, 2);
    vectors++;
    if (obs_first_stb != hs_cycle + 1) begin
      miscompares++;
      $display("FAIL read_stb_cycle: got %0d, required %0d", obs_first_stb, hs_cycle + 1);
    end
    vectors++;
    if (obs_resp_cycle != hs_cycle + 3) begin
      miscompares++;
      $display("FAIL read_latency: got resp at %0d, required %0d", obs_resp_cycle, hs_cycle + 3);
    end
    vectors++;
    if (obs_cyc_at_resp !== 1'b0) begin
      miscompares++;
      $display("FAIL read_cyc_drop: got cyc_o=%b after ack, required 0", obs_cyc_at_resp);
    end
  endtask

  task automatic test_write_stall();
    set_slave(4);
    rd_data = 32'hCAFEF00D;
    out_q.push_back(OUT_ACK);
    do_req(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, {2'b00, 32'h0}, 1'b1);
    observe(30, 3);
    set_slave(0);
    vectors++;
    if (obs_stb_cycles != 5 || obs_strobes != 1) begin
      miscompares++;
      $display("FAIL write_stall_stb: got %0d stb cycles in %0d strobes, required 5 in 1",
               obs_stb_cycles, obs_strobes);
    end
    vectors++;
    if (obs_bad_fields != 0) begin
      miscompares++;
      $display("FAIL write_fields_stable: got %0d unstable cycles, required 0", obs_bad_fields);
    end
    vectors++;
    if (obs_resp != 1) begin
      miscompares++;
      $display("FAIL write_single_resp: got %0d responses, required 1", obs_resp);
    end
  endtask

  task automatic test_retry();
    logic [DW-1:0] d;
    set_slave(0);
    d = $urandom;
    rd_data = d;
    for (int i = 0; i < 3; i++) out_q.push_back(OUT_RTY);
    out_q.push_back(OUT_ACK);
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b00, d}, 1'b1);
    observe(60, 2);
    vectors++;
    if (obs_strobes != 4 || obs_gaps != 3) begin
      miscompares++;
      $display("FAIL retry_ok_shape: got %0d strobes %0d gaps, required 4 and 3", obs_strobes, obs_gaps);
    end
    for (int i = 0; i < 4; i++) out_q.push_back(OUT_RTY);
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b10, 32'h0}, 1'b1);
    observe(60, 2);
    vectors++;
    if (obs_strobes != 4 || obs_gaps != 3) begin
      miscompares++;
      $display("FAIL retry_exhaust_shape: got %0d strobes %0d gaps, required 4 and 3", obs_strobes, obs_gaps);
    end
  endtask

  task automatic test_timeout();
    int stray_resp;
    set_slave(0);
    out_q.delete();
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b11, 32'h0}, 1'b1);
    observe(300, 0);
    vectors++;
    if (obs_resp_cycle - obs_first_stb != 256) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles, required 256", obs_resp_cycle - obs_first_stb);
    end
    stray_req = 1'b1;
    stray_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_bus);
      if (resp_valid === 1'b1 || cyc_o === 1'b1) stray_resp++;
    end
    vectors++;
    if (stray_resp != 0) begin
      miscompares++;
      $display("FAIL stray_ack: got %0d active cycles, required 0", stray_resp);
    end
  endtask

  task automatic test_ack_err();
    logic [DW-1:0] d;
    set_slave(0);
    d = $urandom;
    rd_data = d;
    out_q.push_back(OUT_ACKERR);
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b00, d}, 1'b1);
    observe(20, 1);
    vectors++;
    if (obs_resp != 1) begin
      miscompares++;
      $display("FAIL ack_err_resp: got %0d responses, required 1", obs_resp);
    end
    out_q.push_back(OUT_ERR);
    do_req(1'b1, $urandom, $urandom, 4'($urandom_range(1, 15)), {2'b10, 32'h0}, 1'b1);
    observe(20, 1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    set_slave(0);
    d0 = $urandom;
    d1 = ~d0;
    rd_data = d0;
    out_q.push_back(OUT_ACK);
    out_q.push_back(OUT_ACK);
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b00, d0}, 1'b1);
    observe(20, 0);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got req_ready=%b in resp cycle, required 1", req_ready);
    end
    rd_data = d1;
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b00, d1}, 1'b1);
    observe(20, 1);
    vectors++;
    if (obs_resp_cycle != hs_cycle + 3) begin
      miscompares++;
      $display("FAIL b2b_latency: got resp at %0d, required %0d", obs_resp_cycle, hs_cycle + 3);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [DW-1:0] d;
    set_slave(0);
    out_q.delete();
    do_req(1'b0, $urandom, $urandom, 4'hF, '0, 1'b0);
    @(negedge clk_bus);
    rst_bus = 1'b0;
    @(negedge clk_bus);
    vectors++;
    if ({cyc_o, stb_o, resp_valid, req_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_wait_drop: got cyc/stb/rv/rdy=%b, required 0000",
               {cyc_o, stb_o, resp_valid, req_ready});
    end
    rst_bus = 1'b1;
    @(negedge clk_bus);
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wait_release: got rdy=%b rv=%b, required 1 0", req_ready, resp_valid);
    end
    d = $urandom;
    rd_data = d;
    out_q.push_back(OUT_ACK);
    do_req(1'b0, $urandom, $urandom, 4'hF, {2'b00, d}, 1'b1);
    observe(20, 2);
    vectors++;
    if (obs_resp_cycle != hs_cycle + 3) begin
      miscompares++;
      $display("FAIL reset_wait_read: got resp at %0d, required %0d", obs_resp_cycle, hs_cycle + 3);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_retry();
    test_timeout();
    test_ack_err();
    test_back_to_back();
    test_reset_in_wait();
    repeat (3) @(negedge clk_bus);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expected: got %0d unmatched, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
